// File: rtl/ustc_tile_engine.sv
// ustc_tile_engine: sparse-A x dense-B tile engine.
// Each beat carries N_NZ compressed A nonzeros (value, row, col, valid) and a dense
// TILE_K x TILE_N block of B. Nonzeros gather their B row by column index, are
// multiplied, and are scatter-accumulated by row index into a TILE_M x TILE_N tile.
// The tile is presented on out_c with a valid/ready handshake after the last beat.
module ustc_tile_engine #(
  parameter int TILE_M  = 4,
  parameter int TILE_K  = 8,
  parameter int TILE_N  = 4,
  parameter int N_NZ    = 8,
  parameter int DW_DATA = 8,
  parameter int DW_ACC  = 32,
  parameter int DW_ROW  = (TILE_M > 1) ? $clog2(TILE_M) : 1,
  parameter int DW_IDX  = (TILE_K > 1) ? $clog2(TILE_K) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              signed_en,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  input  logic [N_NZ*DW_DATA-1:0]           in_a,
  input  logic [N_NZ*DW_ROW-1:0]            in_a_row,
  input  logic [N_NZ*DW_IDX-1:0]            in_a_col,
  input  logic [N_NZ-1:0]                   in_a_vld,
  input  logic [TILE_K*TILE_N*DW_DATA-1:0]  in_b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [TILE_M*TILE_N*DW_ACC-1:0]   out_c
);

  localparam int PW = 2 * DW_DATA;

  typedef enum logic {ST_ACCUM, ST_DRAIN} state_t;

  state_t state;
  logic   accept;

  // Gather stage (combinational) and S1 registers
  logic [DW_DATA-1:0] g_b   [N_NZ][TILE_N];
  logic [N_NZ-1:0]    g_vld;
  logic [DW_DATA-1:0] s1_a  [N_NZ];
  logic [DW_ROW-1:0]  s1_row[N_NZ];
  logic [DW_DATA-1:0] s1_b  [N_NZ][TILE_N];
  logic [N_NZ-1:0]    s1_vld;
  logic               s1_signed;
  logic               s1_valid;
  logic               s1_last;

  // Multiply stage (combinational) and S2 registers
  logic [PW-1:0]      p_next[N_NZ][TILE_N];
  logic [PW-1:0]      s2_p  [N_NZ][TILE_N];
  logic [DW_ROW-1:0]  s2_row[N_NZ];
  logic [N_NZ-1:0]    s2_vld;
  logic               s2_signed;
  logic               s2_valid;
  logic               s2_last;

  // Scatter-sum (combinational) and accumulator
  logic [DW_ACC-1:0]  sum[TILE_M][TILE_N];
  logic [DW_ACC-1:0]  acc[TILE_M][TILE_N];

  assign accept = in_valid & in_ready;

  // Extend an operand to product width, two's-complement or unsigned.
  function automatic logic [PW-1:0] extend(input logic [DW_DATA-1:0] v, input logic sgn);
    return sgn ? {{DW_DATA{v[DW_DATA-1]}}, v} : {{DW_DATA{1'b0}}, v};
  endfunction

  // Extend a product to accumulator width, two's-complement or unsigned.
  function automatic logic [DW_ACC-1:0] widen(input logic [PW-1:0] p, input logic sgn);
    return sgn ? DW_ACC'($signed(p)) : DW_ACC'(p);
  endfunction

  // Gather B[col][*] per slot; out-of-range row or col turns the slot off.
  always_comb begin
    // NOTE: every always_comb output gets a default before any condition, so no latch can form.
    g_vld = '0;
    for (int s = 0; s < N_NZ; s++) begin
      int col;
      int row;
      col = int'(in_a_col[s*DW_IDX +: DW_IDX]);
      row = int'(in_a_row[s*DW_ROW +: DW_ROW]);
      g_vld[s] = in_a_vld[s] && (row < TILE_M) && (col < TILE_K);
      for (int n = 0; n < TILE_N; n++) begin
        g_b[s][n] = '0;
        if (col < TILE_K) g_b[s][n] = in_b[(col*TILE_N + n)*DW_DATA +: DW_DATA];
      end
    end
  end

  // Per-slot, per-column products at 2*DW_DATA bits; the low half of the
  // product of extended operands is exact for both signed and unsigned.
  always_comb begin
    for (int s = 0; s < N_NZ; s++) begin
      for (int n = 0; n < TILE_N; n++) begin
        p_next[s][n] = extend(s1_a[s], s1_signed) * extend(s1_b[s][n], s1_signed);
      end
    end
  end

  // Scatter: each accumulator cell sums every valid slot targeting its row.
  always_comb begin
    for (int m = 0; m < TILE_M; m++) begin
      for (int n = 0; n < TILE_N; n++) begin
        sum[m][n] = '0;
        for (int s = 0; s < N_NZ; s++) begin
          if (s2_vld[s] && (s2_row[s] == DW_ROW'(m)))
            sum[m][n] = sum[m][n] + widen(s2_p[s][n], s2_signed);
        end
      end
    end
  end

  // Datapath pipeline registers; qualified by s1_valid/s2_valid downstream.
  // NOTE: payload registers carry no reset; only the valids and accumulators need a known value.
  always_ff @(posedge clk) begin
    for (int s = 0; s < N_NZ; s++) begin
      s1_a[s]   <= in_a[s*DW_DATA +: DW_DATA];
      s1_row[s] <= in_a_row[s*DW_ROW +: DW_ROW];
      s2_row[s] <= s1_row[s];
      for (int n = 0; n < TILE_N; n++) begin
        s1_b[s][n] <= g_b[s][n];
        s2_p[s][n] <= p_next[s][n];
      end
    end
    s1_vld    <= g_vld;
    s1_signed <= signed_en;
    s2_vld    <= s1_vld;
    s2_signed <= s1_signed;
  end

  // Control FSM, pipeline valids, handshakes and accumulator.
  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_ACCUM;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      for (int m = 0; m < TILE_M; m++)
        for (int n = 0; n < TILE_N; n++)
          acc[m][n] <= '0;
    end else begin
      s1_valid <= accept;
      s1_last  <= accept & in_last;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      case (state)
        ST_ACCUM: begin
          if (s2_valid) begin
            for (int m = 0; m < TILE_M; m++)
              for (int n = 0; n < TILE_N; n++)
                acc[m][n] <= acc[m][n] + sum[m][n];
          end
          if (s2_last) begin
            state     <= ST_DRAIN;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
          end else begin
            // Close the input as soon as a last beat is accepted and keep it
            // closed while that beat travels through S1/S2.
            in_ready <= !(accept && in_last) && !s1_last;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            state     <= ST_ACCUM;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            for (int m = 0; m < TILE_M; m++)
              for (int n = 0; n < TILE_N; n++)
                acc[m][n] <= '0;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  // Present the accumulator array as the flat C tile.
  always_comb begin
    out_c = '0;
    for (int m = 0; m < TILE_M; m++)
      for (int n = 0; n < TILE_N; n++)
        out_c[(m*TILE_N + n)*DW_ACC +: DW_ACC] = acc[m][n];
  end

endmodule

// File: tb/tb_ustc_tile_engine.sv
// Testbench for ustc_tile_engine: directed scenarios plus randomized tiles.
// A matrix-level reference model builds each expected C tile; a monitor checks
// it when the DUT presents out_valid. A second instance with a 16-bit
// accumulator runs in lockstep to observe modulo wrap.
module tb_ustc_tile_engine;

  localparam int TM = 4;
  localparam int TK = 8;
  localparam int TN = 4;
  localparam int NZ = 8;
  localparam int DW = 8;
  localparam int RW = 2;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic signed_en;
  logic in_valid;
  logic in_last;
  logic [NZ*DW-1:0]    in_a;
  logic [NZ*RW-1:0]    in_a_row;
  logic [NZ*IW-1:0]    in_a_col;
  logic [NZ-1:0]       in_a_vld;
  logic [TK*TN*DW-1:0] in_b;
  logic out_ready;
  logic in_ready, in_ready16;
  logic out_valid, out_valid16;
  logic [TM*TN*32-1:0] out_c;
  logic [TM*TN*16-1:0] out_c16;

  ustc_tile_engine #(.DW_ACC(32)) dut (
    .clk(clk), .reset(rst_n), .signed_en(signed_en), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_a(in_a), .in_a_row(in_a_row),
    .in_a_col(in_a_col), .in_a_vld(in_a_vld), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_c(out_c)
  );

  ustc_tile_engine #(.DW_ACC(16)) dut16 (
    .clk(clk), .reset(rst_n), .signed_en(signed_en), .in_valid(in_valid),
    .in_ready(in_ready16), .in_last(in_last), .in_a(in_a), .in_a_row(in_a_row),
    .in_a_col(in_a_col), .in_a_vld(in_a_vld), .in_b(in_b), .out_valid(out_valid16),
    .out_ready(out_ready), .out_c(out_c16)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Beat under construction
  logic [DW-1:0] ba [NZ];
  logic [RW-1:0] br [NZ];
  logic [IW-1:0] bc [NZ];
  logic [NZ-1:0] bv;
  logic [DW-1:0] bb [TK][TN];
  logic          bsig;

  // Reference model: running C tile as plain integers
  longint macc [TM][TN];
  logic [TM*TN*64-1:0] exp_q[$];
  int last_acc_cyc = 0;
  int hold_req = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_beat();
    for (int s = 0; s < NZ; s++) begin ba[s] = '0; br[s] = '0; bc[s] = '0; end
    for (int k = 0; k < TK; k++) for (int n = 0; n < TN; n++) bb[k][n] = '0;
    bv = '0;
    bsig = 1'b0;
  endtask

  task automatic random_beat();
    for (int s = 0; s < NZ; s++) begin
      ba[s] = DW'($urandom); br[s] = RW'($urandom); bc[s] = IW'($urandom);
    end
    for (int k = 0; k < TK; k++) for (int n = 0; n < TN; n++) bb[k][n] = DW'($urandom);
    bv = NZ'($urandom);
    bsig = 1'($urandom);
  endtask

  task automatic clear_model();
    for (int m = 0; m < TM; m++) for (int n = 0; n < TN; n++) macc[m][n] = 0;
  endtask

  function automatic int val(input logic [DW-1:0] v, input logic sgn);
    int r;
    r = int'(v);
    if (sgn && v[DW-1]) r = r - 256;
    return r;
  endfunction

  // C[row][n] += A value * B[col][n] for every valid nonzero.
  task automatic model_beat();
    for (int s = 0; s < NZ; s++)
      if (bv[s])
        for (int n = 0; n < TN; n++)
          macc[br[s]][n] += longint'(val(ba[s], bsig) * val(bb[bc[s]][n], bsig));
  endtask

  task automatic send_beat(input logic last);
    int waitc;
    for (int s = 0; s < NZ; s++) begin
      in_a[s*DW +: DW] = ba[s];
      in_a_row[s*RW +: RW] = br[s];
      in_a_col[s*IW +: IW] = bc[s];
    end
    for (int k = 0; k < TK; k++)
      for (int n = 0; n < TN; n++)
        in_b[(k*TN + n)*DW +: DW] = bb[k][n];
    in_a_vld = bv;
    signed_en = bsig;
    in_last = last;
    in_valid = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 64) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    model_beat();
    if (last) begin
      logic [TM*TN*64-1:0] e;
      for (int m = 0; m < TM; m++)
        for (int n = 0; n < TN; n++)
          e[(m*TN + n)*64 +: 64] = macc[m][n];
      last_acc_cyc = cyc;
      exp_q.push_back(e);
      clear_model();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int waitc;
    waitc = 0;
    while ((exp_q.size() != 0 || out_valid) && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("drain_idle", (exp_q.size() == 0 && !out_valid), 1'b1);
  endtask

  // Monitor: pop expected tile on the first out_valid cycle, then check it is held.
  initial begin
    bit in_tile;
    int hold;
    logic [511:0] snap;
    logic [255:0] snap16;
    logic [TM*TN*64-1:0] e;
    logic [511:0] e32;
    logic [255:0] e16;
    in_tile = 0;
    hold = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_tile = 0; hold = 0; out_ready = 1'b1;
      end else if (out_valid) begin
        if (!in_tile) begin
          in_tile = 1;
          check("tile_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < TM*TN; i++) begin
              e32[i*32 +: 32] = e[i*64 +: 32];
              e16[i*16 +: 16] = e[i*64 +: 16];
            end
            check("c_tile_acc32", out_c, e32);
            check("c_tile_acc16", out_c16, e16);
          end
          check("latency", cyc - last_acc_cyc, 2);
          check("valid16", out_valid16, 1'b1);
          check("drain_in_ready", in_ready, 1'b0);
          check("ready16", in_ready16, in_ready);
          snap = out_c;
          snap16 = out_c16;
          hold = hold_req;
          hold_req = 0;
          out_ready = (hold == 0);
        end else begin
          check("hold_c", out_c, snap);
          check("hold_c16", out_c16, snap16);
          check("hold_in_ready", in_ready, 1'b0);
          if (hold > 0) hold--;
          out_ready = (hold == 0);
        end
      end else begin
        if (in_tile) check("ready_after_drain", in_ready, 1'b1);
        in_tile = 0;
        out_ready = 1'b1;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    signed_en = 1'b0;
    in_a = '0; in_a_row = '0; in_a_col = '0; in_a_vld = '0; in_b = '0;
    clear_beat();
    clear_model();

    // Reset state
    #3;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_c", out_c, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("ready_before_edge", in_ready, 1'b0);
    @(posedge clk); #1;
    check("ready_after_release", in_ready, 1'b1);

    // Single beat tile: C[1][*] = 3 * {1,2,3,4}
    clear_beat();
    ba[0] = 8'd3; br[0] = 2'd1; bc[0] = 3'd2; bv = 8'h01;
    bb[2][0] = 8'd1; bb[2][1] = 8'd2; bb[2][2] = 8'd3; bb[2][3] = 8'd4;
    send_beat(1'b1);

    // Two slots to the same row: C[0][n] = 2 + 5
    clear_beat();
    ba[0] = 8'd2; br[0] = 2'd0; bc[0] = 3'd0;
    ba[1] = 8'd5; br[1] = 2'd0; bc[1] = 3'd1;
    bv = 8'h03;
    for (int n = 0; n < TN; n++) begin bb[0][n] = 8'd1; bb[1][n] = 8'd1; end
    send_beat(1'b1);

    // Signed / unsigned interpretation of identical bytes, four beats each
    for (int t = 0; t < 4; t++) begin
      clear_beat();
      bsig = t[0] ? 1'b0 : 1'b1;
      ba[0] = (t < 2) ? 8'h80 : 8'hFF;
      bb[0][0] = (t < 2) ? 8'h80 : 8'h02;
      bv = 8'h01;
      for (int b = 0; b < 4; b++) send_beat(b == 3);
    end

    // Backpressure for 10 cycles, then a tile that must start from zero
    wait_idle();
    hold_req = 10;
    clear_beat();
    ba[3] = 8'd7; br[3] = 2'd2; bc[3] = 3'd5; bv = 8'h08;
    for (int n = 0; n < TN; n++) bb[5][n] = 8'(n + 1);
    send_beat(1'b1);
    clear_beat();
    ba[0] = 8'd1; br[0] = 2'd2; bc[0] = 3'd0; bv = 8'h01; bb[0][0] = 8'd9;
    send_beat(1'b1);

    // Wrap: each beat adds 0xFFFF to C[0][0]
    clear_beat();
    ba[0] = 8'hFF; bc[0] = 3'd0;
    ba[1] = 8'hFF; bc[1] = 3'd1;
    bv = 8'h03;
    bb[0][0] = 8'hFF; bb[1][0] = 8'h02;
    send_beat(1'b0);
    send_beat(1'b1);

    // All slots invalid: zero tile
    random_beat();
    bv = '0;
    send_beat(1'b1);

    // Reset mid-tile: partial sums are discarded
    wait_idle();
    for (int b = 0; b < 3; b++) begin random_beat(); send_beat(1'b0); end
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_c", out_c, '0);
    check("midrst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
    @(posedge clk); #1;
    check("midrst_ready_back", in_ready, 1'b1);
    random_beat();
    send_beat(1'b1);

    // Randomized tiles with bubbles and occasional backpressure
    for (int t = 0; t < 30; t++) begin
      int nb;
      nb = $urandom_range(1, 5);
      if ($urandom_range(0, 3) == 0) hold_req = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        idle($urandom_range(0, 2));
        random_beat();
        send_beat(b == nb - 1);
      end
    end

    wait_idle();
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
